// File: rtl/combo_lock_pkg.sv
// Shared types, widths and helpers for the combination lock controller.
package combo_lock_pkg;

    localparam int unsigned TIMER_W = 26;
    localparam int unsigned SEQ_LEN = 4;
    localparam int unsigned BTN_W   = 2;
    localparam int unsigned DIGIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } lock_state_e;

    // True when exactly one button bit is set.
    function automatic logic btn_is_onehot(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

    // Button index of a one-hot pulse vector.
    function automatic logic [BTN_W-1:0] btn_index(input logic [3:0] b);
        if (b[3])      return 2'd3;
        else if (b[2]) return 2'd2;
        else if (b[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // Expected button index for press position pos (press 0 is the MSB pair).
    function automatic logic [BTN_W-1:0] code_digit(input logic [7:0] code,
                                                     input logic [DIGIT_W-1:0] pos);
        case (pos)
            3'd0:    return code[7:6];
            3'd1:    return code[5:4];
            3'd2:    return code[3:2];
            default: return code[1:0];
        endcase
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry, unlock and lockout intervals.
module lock_timer
    import combo_lock_pkg::*;
(
    input  logic               clk5,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               done
);

    logic [TIMER_W-1:0] r_count;

    // Load wins; outside timed states the count is parked at zero; never wraps.
    always_ff @(posedge clk5) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (!en) begin
            r_count <= '0;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign done = en && (r_count == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Code-entry controller: checks a 4-press sequence, drives unlock/err/lockout.
module combo_lock_fsm
    import combo_lock_pkg::*;
#(
    parameter logic [7:0]         CODE           = 8'b00_01_10_11,
    parameter logic [1:0]         MAX_FAILS      = 2'd3,
    parameter logic [TIMER_W-1:0] UNLOCK_CYCLES  = 26'd25000000,
    parameter logic [TIMER_W-1:0] LOCKOUT_CYCLES = 26'd50000000,
    parameter logic [TIMER_W-1:0] ENTRY_TIMEOUT  = 26'd15000000
)
(
    input  logic         clk5,
    input  logic         reset,
    input  logic [3:0]   btn_pulse,
    output logic         unlocked,
    output logic         err,
    output logic         locked_out,
    output logic [2:0]   digit_cnt,
    output logic [1:0]   fail_cnt
);

    lock_state_e          r_state;
    logic                 r_mismatch;
    logic                 r_unlocked;
    logic                 r_err;
    logic                 r_locked_out;
    logic [DIGIT_W-1:0]   r_digit_cnt;
    logic [1:0]           r_fail_cnt;

    logic                 w_press;
    logic                 w_bad_now;
    logic                 w_last;
    logic                 w_code_ok;
    logic [1:0]           w_fails_inc;
    logic                 w_tmr_load;
    logic [TIMER_W-1:0]   w_tmr_val;
    logic                 w_tmr_en;
    logic                 w_tmr_done;

    assign w_press     = |btn_pulse;
    assign w_bad_now   = !btn_is_onehot(btn_pulse) ||
                         (btn_index(btn_pulse) != code_digit(CODE, r_digit_cnt));
    assign w_last      = (r_digit_cnt == DIGIT_W'(SEQ_LEN - 1));
    assign w_code_ok   = !(r_mismatch || w_bad_now);
    assign w_fails_inc = r_fail_cnt + 2'd1;
    assign w_tmr_en    = (r_state != ST_IDLE);

    // Timer load on entry to a timed state, or on each accepted digit.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = ENTRY_TIMEOUT - TIMER_W'(1);
                end
            end
            ST_ENTRY: begin
                if (w_press) begin
                    if (!w_last) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = ENTRY_TIMEOUT - TIMER_W'(1);
                    end else if (w_code_ok) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = UNLOCK_CYCLES - TIMER_W'(1);
                    end else if (w_fails_inc == MAX_FAILS) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = LOCKOUT_CYCLES - TIMER_W'(1);
                    end
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    lock_timer u_timer (
        .clk5     (clk5),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .done     (w_tmr_done)
    );

    // Lock state machine with registered indications.
    always_ff @(posedge clk5) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mismatch   <= 1'b0;
            r_unlocked   <= 1'b0;
            r_err        <= 1'b0;
            r_locked_out <= 1'b0;
            r_digit_cnt  <= '0;
            r_fail_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_digit_cnt <= DIGIT_W'(1);
                        r_mismatch  <= w_bad_now;
                        r_state     <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (w_press) begin
                        if (w_last) begin
                            r_digit_cnt <= '0;
                            r_mismatch  <= 1'b0;
                            if (w_code_ok) begin
                                r_state    <= ST_OPEN;
                                r_unlocked <= 1'b1;
                                r_fail_cnt <= '0;
                            end else begin
                                r_err      <= 1'b1;
                                r_fail_cnt <= w_fails_inc;
                                if (w_fails_inc == MAX_FAILS) begin
                                    r_state      <= ST_LOCKOUT;
                                    r_locked_out <= 1'b1;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end else begin
                            r_digit_cnt <= DIGIT_W'(r_digit_cnt + 3'd1);
                            r_mismatch  <= r_mismatch | w_bad_now;
                        end
                    end else if (w_tmr_done) begin
                        r_state     <= ST_IDLE;
                        r_digit_cnt <= '0;
                        r_mismatch  <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (w_press || w_tmr_done) begin
                        r_state    <= ST_IDLE;
                        r_unlocked <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_tmr_done) begin
                        r_state      <= ST_IDLE;
                        r_locked_out <= 1'b0;
                        r_fail_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign unlocked   = r_unlocked;
    assign err        = r_err;
    assign locked_out = r_locked_out;
    assign digit_cnt  = r_digit_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: directed scenarios plus random presses vs. a reference model.
module tb_combo_lock_fsm;

    localparam logic [7:0] CODE     = 8'b00_01_10_11;
    localparam int         UNLOCK   = 20;
    localparam int         LOCKOUT  = 40;
    localparam int         ENTRY_TO = 30;
    localparam int         MAXF     = 3;

    logic       clk5 = 1'b0;
    logic       reset;
    logic [3:0] btn_pulse;
    logic       unlocked;
    logic       err;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    combo_lock_fsm #(
        .CODE           (CODE),
        .MAX_FAILS      (2'(MAXF)),
        .UNLOCK_CYCLES  (26'(UNLOCK)),
        .LOCKOUT_CYCLES (26'(LOCKOUT)),
        .ENTRY_TIMEOUT  (26'(ENTRY_TO))
    ) dut (
        .clk5       (clk5),
        .reset      (reset),
        .btn_pulse  (btn_pulse),
        .unlocked   (unlocked),
        .err        (err),
        .locked_out (locked_out),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk5 = ~clk5;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: digits typed so far, idle gap, remaining open/lockout time.
    int m_q[$];
    int m_gap   = 0;
    int m_open  = 0;
    int m_lock  = 0;
    int m_fails = 0;
    int m_err   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    endtask

    function automatic int code_at(input int i);
        int c;
        c = int'(CODE);
        return (c >> (6 - 2 * i)) & 3;
    endfunction

    function automatic int press_val(input logic [3:0] b);
        int idx;
        idx = -1;
        if ($countones(b) == 1) begin
            for (int i = 0; i < 4; i++) if (b[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] b);
        bit ok;
        if (rst) begin
            m_q.delete();
            m_gap = 0; m_open = 0; m_lock = 0; m_fails = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_open > 0) begin
            if (b != 4'd0) m_open = 0;
            else           m_open--;
        end else if (b != 4'd0) begin
            m_q.push_back(press_val(b));
            m_gap = 0;
            if (m_q.size() == 4) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (m_q[i] != code_at(i)) ok = 1'b0;
                m_q.delete();
                if (ok) begin
                    m_open  = UNLOCK;
                    m_fails = 0;
                end else begin
                    m_err = 1;
                    m_fails++;
                    if (m_fails == MAXF) m_lock = LOCKOUT;
                end
            end
        end else if (m_q.size() > 0) begin
            m_gap++;
            if (m_gap == ENTRY_TO) m_q.delete();
        end
    endtask

    // One clock: drive, advance model at the edge, compare just after it.
    task automatic tick(input logic rst, input logic [3:0] b);
        reset     = rst;
        btn_pulse = b;
        @(posedge clk5);
        model_step(rst, b);
        cyc++;
        #1;
        check_val("unlocked",   int'(unlocked),   (m_open > 0) ? 1 : 0);
        check_val("err",        int'(err),        m_err);
        check_val("locked_out", int'(locked_out), (m_lock > 0) ? 1 : 0);
        check_val("digit_cnt",  int'(digit_cnt),  m_q.size());
        check_val("fail_cnt",   int'(fail_cnt),   m_fails);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b2,
                          input logic [3:0] c, input logic [3:0] d, input int gap);
        tick(1'b0, a);  idle(gap);
        tick(1'b0, b2); idle(gap);
        tick(1'b0, c);  idle(gap);
        tick(1'b0, d);
    endtask

    initial begin
        logic [3:0] b;
        int r, s;
        reset     = 1'b1;
        btn_pulse = 4'd0;
        tick(1'b1, 4'd0);
        tick(1'b1, 4'd0);

        // Correct code, presses 5 cycles apart; hold time then auto-relock.
        enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 4);
        idle(25);

        // Wrong last digit.
        enter4(4'b0001, 4'b0010, 4'b0100, 4'b0100, 1);
        idle(5);

        // Two more wrong codes -> lockout; presses during lockout ignored.
        enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001, 0);
        enter4(4'b1000, 4'b0010, 4'b0100, 4'b1000, 0);
        tick(1'b0, 4'b0001); idle(3); tick(1'b0, 4'b0010); idle(3);
        tick(1'b0, 4'b0100);
        idle(40);

        // Partial entry abandoned by timeout, then a correct code.
        tick(1'b0, 4'b0001); tick(1'b0, 4'b0010);
        idle(32);
        enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1);

        // Early relock from a press while open.
        idle(6);
        tick(1'b0, 4'b0100);
        idle(5);

        // Multi-bit first press forces mismatch.
        enter4(4'b0011, 4'b0010, 4'b0100, 4'b1000, 1);
        idle(3);

        // Reset in the middle of lockout.
        enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001, 0);
        enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001, 0);
        idle(10);
        tick(1'b1, 4'd0);
        idle(5);

        // Random presses biased toward the right code.
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                tick(1'b1, 4'd0);
            end else if (r < 250) begin
                s = int'($urandom_range(0, 9));
                if (s < 6)      b = 4'(1 << code_at(m_q.size() % 4));
                else if (s < 9) b = 4'(1 << $urandom_range(0, 3));
                else            b = 4'($urandom_range(1, 15));
                tick(1'b0, b);
            end else begin
                tick(1'b0, 4'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
